// File: rtl/mac_fp16_pkg.sv
// Shared types and constants for the FP16 MAC feeder and the MAC_FP_16 bench.
package mac_fp16_pkg;

    typedef enum logic [2:0] {
        CLEAR  = 3'd0,
        SETTLE = 3'd1,
        ACCEPT = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } state_t;

    localparam logic [15:0] FP16_ZERO = 16'h0000;
    localparam logic [15:0] FP16_ONE  = 16'h3C00;

    // Edges from operand load to the edge after which mac_acc holds the product.
    localparam int MAC_LATENCY = 7;

endpackage

// File: rtl/mac_fp16_feeder.sv
// Sequencer feeding operand pairs into MAC_FP_16: clears the MAC before each job,
// streams beats, waits out the pipeline and presents the final accumulator.
module mac_fp16_feeder
    import mac_fp16_pkg::*;
#(
    parameter int LATENCY       = MAC_LATENCY,
    parameter int FLUSH_CYCLES  = 5,
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        in_a,
    input  logic [15:0]        in_b,
    input  logic               in_last,
    output logic [15:0]        mac_a,
    output logic [15:0]        mac_b,
    output logic               mac_rst,
    input  logic [15:0]        mac_acc,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [15:0]        res_data,
    output logic [COUNT_W-1:0] res_count,
    output logic               busy,
    output state_t             dbg_state
);

    // Handshake: a beat moves on a rising edge with in_valid && in_ready, a result
    // on a rising edge with res_valid && res_ready; neither ready nor valid
    // depends combinationally on the opposite side.

    localparam int WAIT_MAX = (LATENCY > FLUSH_CYCLES)
                            ? ((LATENCY > SETTLE_CYCLES) ? LATENCY : SETTLE_CYCLES)
                            : ((FLUSH_CYCLES > SETTLE_CYCLES) ? FLUSH_CYCLES : SETTLE_CYCLES);
    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    state_t             state;
    state_t             state_next;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [COUNT_W-1:0] beat_cnt;
    logic               xfer;
    logic               drain_done;

    assign xfer       = in_valid && in_ready;
    assign drain_done = (state == DRAIN) && (wait_cnt == WAIT_W'(LATENCY - 1));
    assign dbg_state  = state;

    // State register and phase counter; the counter restarts on every state change,
    // so the last-beat edge itself is the first counted DRAIN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (state != ACCEPT && state != RESULT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (wait_cnt == WAIT_W'(FLUSH_CYCLES - 1))  state_next = SETTLE;
            SETTLE:  if (wait_cnt == WAIT_W'(SETTLE_CYCLES - 1)) state_next = ACCEPT;
            ACCEPT:  if (xfer && in_last)                        state_next = DRAIN;
            DRAIN:   if (drain_done)                             state_next = RESULT;
            RESULT:  if (res_ready)                              state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_comb begin
        mac_rst   = (state == CLEAR);
        in_ready  = (state == ACCEPT);
        res_valid = (state == RESULT);
        busy      = !((state == ACCEPT) && (beat_cnt == '0));
    end

    // Operand path: any edge without a transfer feeds +0, which leaves the sum alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            mac_a     <= FP16_ZERO;
            mac_b     <= FP16_ZERO;
            beat_cnt  <= '0;
            res_data  <= FP16_ZERO;
            res_count <= '0;
        end else begin
            mac_a <= xfer ? in_a : FP16_ZERO;
            mac_b <= xfer ? in_b : FP16_ZERO;
            if (xfer && (beat_cnt != {COUNT_W{1'b1}})) begin
                beat_cnt <= beat_cnt + COUNT_W'(1);
            end
            if (drain_done) begin
                res_data  <= mac_acc;
                res_count <= beat_cnt;
            end
            if (state == RESULT && res_ready) begin
                beat_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/mac_fp16_feeder.md
# mac_fp16_feeder

Initiator-side sequencer for the FP16 multiply-accumulate unit (`MAC_FP_16`). It accepts a stream of operand pairs with valid/ready handshake, where `in_last` marks the end of one dot-product job. Before each job it clears the MAC with a zero-fed reset sequence, then drives one operand pair per accepted beat. After the last beat it waits out the MAC pipeline latency and returns the final accumulator value on a valid/ready result port. It sits between the operand source (buffer or DMA) and the MAC, and owns all MAC clearing and latency bookkeeping.

## Interface
- `LATENCY`, 7: rising edges from the edge that loads an operand pair onto `mac_a`/`mac_b` to the edge after which `mac_acc` includes that product.
- `FLUSH_CYCLES`, 5: cycles `mac_rst` is held high per clear.
- `SETTLE_CYCLES`, 2: zero-fed cycles after `mac_rst` falls, before operands are accepted.
- `COUNT_W`, 16: width of the beat counter.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: feeder accepts a beat.
- `in_a` input 16: FP16 operand A.
- `in_b` input 16: FP16 operand B.
- `in_last` input 1: the beat is the final beat of the job.
- `mac_a` output 16: registered operand A to the MAC.
- `mac_b` output 16: registered operand B to the MAC.
- `mac_rst` output 1: synchronous clear to the MAC.
- `mac_acc` input 16: MAC accumulator output.
- `res_valid` output 1: result available.
- `res_ready` input 1: consumer takes the result.
- `res_data` output 16: FP16 dot-product result.
- `res_count` output COUNT_W: number of beats in the job. Saturates at all-ones.
- `busy` output 1: high in every state except ACCEPT with no beat yet taken.

## Operation
- States: CLEAR → SETTLE → ACCEPT → DRAIN → RESULT → CLEAR.
- **CLEAR**
  - `mac_rst`=1, `mac_a`=`mac_b`=0 for FLUSH_CYCLES cycles.
  - Then go to SETTLE.
- **SETTLE**
  - `mac_rst`=0, operands 0 for SETTLE_CYCLES cycles.
  - Then go to ACCEPT.
- **ACCEPT**
  - `in_ready`=1. A beat transfers when `in_valid && in_ready` at a rising edge.
  - On a transfer, `mac_a`/`mac_b` load `in_a`/`in_b` and the beat counter increments.
  - On any edge without a transfer, `mac_a`/`mac_b` load 0. A zero bubble adds +0 and leaves the accumulator unchanged.
  - A transfer with `in_last`=1 moves to DRAIN and clears the wait counter.
- **DRAIN**
  - `in_ready`=0, operands 0.
  - Count LATENCY edges starting from the last-beat edge.
  - On the LATENCY-th edge, capture `mac_acc` into `res_data` and the beat count into `res_count`, then go to RESULT.
- **RESULT**
  - `res_valid`=1. `res_data` and `res_count` hold stable until `res_valid && res_ready` at an edge.
  - On that edge, drop `res_valid`, clear the beat counter and go to CLEAR.
- Each job is independent: the accumulator is always cleared between jobs.
- Arithmetic: none in this block. FP16 bits pass through untouched. The beat counter saturates at 2^COUNT_W−1.

## Timing
- Reset values:
  - state CLEAR, counters 0.
  - `mac_rst`=1, `mac_a`=`mac_b`=0.
  - `in_ready`=0, `res_valid`=0, `res_data`=0, `res_count`=0, `busy`=1.
- Reset mid-operation (any state): the pending result is discarded. The full CLEAR+SETTLE sequence is re-run and no `res_valid` is produced for the aborted job.
- First `in_ready` appears FLUSH_CYCLES+SETTLE_CYCLES edges after `rst` falls (7 at defaults).
- Result latency: `res_valid` rises at the edge LATENCY edges after the last-beat transfer edge. At default that is 7 edges, independent of job length.
- `in_ready` depends only on state. It must not depend combinationally on `in_valid`.
- `in_valid` gaps inside a job are legal and do not change the result.
- `res_ready` held high in RESULT gives a 1-cycle `res_valid` pulse. Back-pressure is unbounded.

## Structure
- Package `mac_fp16_pkg` holds:
  - the state enum;
  - `FP16_ZERO` = 16'h0000 and `FP16_ONE` = 16'h3C00;
  - the default latency constant (7), shared with `MAC_FP_16` verification.
- No sub-module: FSM plus two counters inline. `MAC_FP_16` is instantiated only in the test bench and system top.

## Test plan
- Job (3C00,3C00),(4000,4000,last) → `res_data`=4500 (5.0), `res_count`=2, `res_valid` 7 edges after the last beat.
- Job (BE00,4000,last) run after the 5.0 job → `res_data`=C200 (−3.0). Proves the clear between jobs.
- Four back-to-back (3C00,3C00) beats, last on the 4th → `res_data`=4400 (4.0), `res_count`=4.
- Job (4500,0000,last) → `res_data`=0000. Repeat the 4×1.0 job with `in_valid` low on alternate cycles → still 4400.
- Hold `res_ready`=0 for 10 cycles in RESULT → `res_valid` and `res_data` stable and `in_ready`=0; the result is taken on the first `res_ready` cycle.
- Assert `rst` during DRAIN → no `res_valid`, `mac_rst` high for 5 cycles. A following (3C00,3C00,last) job returns 3C00.
